window_fetch_unit: RTL and testbench

- Reads a 4x4 candidate window from data memory, one 32-bit word per cycle.
- Consumes the base/offset window addressing used by the main-path window generator: address = base + row*stride + col*WORD_BYTES.
- Collects the 16 words into an output buffer and hands the full window to the SAD stage via a valid/ready handshake.

---
 rtl/window_fetch_unit_pkg.sv | 23 ++
 rtl/window_addr_counter.sv | 56 +++++
 rtl/window_fetch_unit.sv | 97 +++++++++
 tb/tb_window_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_fetch_unit_pkg.sv
// Shared constants, state encoding and slot-index helper for the window fetch unit.
package window_fetch_unit_pkg;

   localparam int WIN_DIM    = 4;
   localparam int WIN_WORDS  = WIN_DIM * WIN_DIM;
   localparam int WORD_BYTES = 4;
   localparam int IDX_W      = $clog2(WIN_WORDS);
   localparam int DIM_W      = $clog2(WIN_DIM);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Row-major flattened slot index: row*WIN_DIM + col.
   function automatic logic [IDX_W-1:0] slot_index(input logic [DIM_W-1:0] row,
                                                   input logic [DIM_W-1:0] col);
      return IDX_W'(row) * IDX_W'(WIN_DIM) + IDX_W'(col);
   endfunction

endpackage

// File: rtl/window_addr_counter.sv
// Walks the window in row-major order: column offset plus a row-start accumulator, no multiplier.
module window_addr_counter
   import window_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] row_stride,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [IDX_W-1:0]  index,
   output logic              last_index
);

   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] row_start;
   logic [ADDR_W-1:0] col_off;
   logic [DIM_W-1:0]  row;
   logic [DIM_W-1:0]  col;

   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, so the update order inside the block does not matter.
      if (!Rst) begin
         stride_q  <= '0;
         row_start <= '0;
         col_off   <= '0;
         row       <= '0;
         col       <= '0;
      end else if (load) begin
         stride_q  <= row_stride;
         row_start <= base_addr;
         col_off   <= '0;
         row       <= '0;
         col       <= '0;
      end else if (advance) begin
         if (col == DIM_W'(WIN_DIM - 1)) begin
            col       <= '0;
            col_off   <= '0;
            row       <= row + DIM_W'(1);
            row_start <= row_start + stride_q;
         end else begin
            col     <= col + DIM_W'(1);
            col_off <= col_off + ADDR_W'(WORD_BYTES);
         end
      end
   end

   // Sums wrap modulo 2^ADDR_W by construction.
   assign mem_addr   = row_start + col_off;
   assign index      = slot_index(row, col);
   assign last_index = (index == IDX_W'(WIN_WORDS - 1));

endmodule

// File: rtl/window_fetch_unit.sv
// Fetches a 4x4 word window from memory and presents it to the SAD stage with valid/ready.
module window_fetch_unit
   import window_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [ADDR_W-1:0]              row_stride,
   output logic                           busy,
   output logic                           mem_rd_en,
   output logic [ADDR_W-1:0]              mem_addr,
   input  logic [DATA_W-1:0]              mem_rd_data,
   output logic                           win_valid,
   input  logic                           win_ready,
   output logic [WIN_WORDS*DATA_W-1:0]    win_data
);

   state_t            state;
   state_t            state_nx;
   logic              accept;
   logic [IDX_W-1:0]  index;
   logic              last_index;
   logic              cap_en;
   logic [IDX_W-1:0]  cap_idx;
   logic [DATA_W-1:0] slots [WIN_WORDS];

   window_addr_counter #(
      .ADDR_W(ADDR_W)
   ) u_addr_counter (
      .Clk        (Clk),
      .Rst        (Rst),
      .load       (accept),
      .advance    (state == FETCH),
      .base_addr  (base_addr),
      .row_stride (row_stride),
      .mem_addr   (mem_addr),
      .index      (index),
      .last_index (last_index)
   );

   always_ff @(posedge Clk) begin
      if (!Rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            if (last_index) state_nx = DRAIN;
         end
         DRAIN: state_nx = DONE;
         DONE: begin
            if (win_ready) begin
               accept   = start;
               state_nx = start ? FETCH : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state == FETCH) || (state == DRAIN);
   assign mem_rd_en = (state == FETCH);
   assign win_valid = (state == DONE);

   // Read data returns one cycle after the strobe, so strobe and index are delayed to match.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cap_en  <= 1'b0;
         cap_idx <= '0;
         // NOTE: the buffer is reset because win_data must read zero after reset; it is only 16 words.
         for (int i = 0; i < WIN_WORDS; i++) slots[i] <= '0;
      end else begin
         cap_en  <= mem_rd_en;
         cap_idx <= index;
         if (cap_en) slots[cap_idx] <= mem_rd_data;
      end
   end

   for (genvar g = 0; g < WIN_WORDS; g++) begin : g_flatten
      assign win_data[g*DATA_W +: DATA_W] = slots[g];
   end

endmodule

// File: tb/tb_window_fetch_unit.sv
// Scoreboard bench: a cycle-level reference model predicts reads, windows and latency; a monitor compares.
module tb_window_fetch_unit;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         start;
   logic [31:0]  base_addr;
   logic [31:0]  row_stride;
   logic         busy;
   logic         mem_rd_en;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_rd_data;
   logic         win_valid;
   logic         win_ready;
   logic [511:0] win_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 Clk = ~Clk;

   window_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .start       (start),
      .base_addr   (base_addr),
      .row_stride  (row_stride),
      .busy        (busy),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .win_data    (win_data)
   );

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a;
   endfunction

   // Memory: data for a strobed address appears one cycle later; poison otherwise.
   always @(posedge Clk) mem_rd_data <= mem_rd_en ? mem_fn(mem_addr) : 32'hDEAD_BEEF;

   // Reference model: a fetch is 17 busy cycles (16 reads + 1 drain) then a held window.
   logic [31:0]  addr_q [$];
   logic [511:0] win_q  [$];
   int           lat_q  [$];
   int           m_busy_left = 0;
   bit           m_done      = 1'b0;
   bit           m_acc;
   logic [31:0]  m_a;
   logic [511:0] m_win;

   always @(posedge Clk) begin
      cyc++;
      if (!Rst) begin
         m_busy_left = 0;
         m_done      = 1'b0;
         addr_q.delete();
         win_q.delete();
         lat_q.delete();
      end else begin
         m_acc = start && ((m_busy_left == 0 && !m_done) || (m_done && win_ready));
         if (m_done && win_ready) m_done = 1'b0;
         if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_done = 1'b1;
         end
         if (m_acc) begin
            m_busy_left = 17;
            for (int r = 0; r < 4; r++) begin
               for (int c = 0; c < 4; c++) begin
                  m_a = base_addr + 32'(r) * row_stride + 32'(c * 4);
                  addr_q.push_back(m_a);
                  m_win[(r*4+c)*32 +: 32] = mem_fn(m_a);
               end
            end
            win_q.push_back(m_win);
            lat_q.push_back(cyc + 17);
         end
      end
   end

   // Monitor: sampled on the falling edge, away from the DUT's active edge.
   bit prev_valid = 1'b0;
   always @(negedge Clk) begin
      if (cyc > 0) begin
         check("busy", busy, m_busy_left > 0);
         check("win_valid", win_valid, m_done);
         check("mem_rd_en", mem_rd_en, m_busy_left >= 2);
         check("busy_valid_exclusive", busy && win_valid, 1'b0);
         if (mem_rd_en) begin
            if (addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mem_addr: unexpected read at %0h, expected no read", mem_addr);
            end else begin
               check("mem_addr", mem_addr, addr_q.pop_front());
            end
         end
         if (win_valid) begin
            if (!prev_valid) begin
               if (lat_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL latency: win_valid rose at cycle %0d, expected no window", cyc);
               end else begin
                  check("latency", cyc, lat_q.pop_front());
               end
            end
            if (win_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL win_data: window %0h presented, expected none", win_data);
            end else begin
               check("win_data", win_data, win_q[0]);
               if (win_ready) void'(win_q.pop_front());
            end
         end
         prev_valid = win_valid;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_start(input logic [31:0] b, input logic [31:0] s);
      start      = 1'b1;
      base_addr  = b;
      row_stride = s;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (win_valid) return;
         tick();
      end
      checks++;
      errors++;
      $display("FAIL wait_valid: win_valid 0 after %0d cycles, expected 1", max_cycles);
   endtask

   task automatic handshake();
      win_ready = 1'b1;
      tick();
      win_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst        = 1'b0;
      start      = 1'b0;
      win_ready  = 1'b0;
      base_addr  = '0;
      row_stride = '0;
      repeat (2) tick();
      check("reset_busy", busy, 1'b0);
      check("reset_rd_en", mem_rd_en, 1'b0);
      check("reset_addr", mem_addr, 32'h0);
      check("reset_valid", win_valid, 1'b0);
      check("reset_data", win_data, '0);
      Rst = 1'b1;
      tick();

      // Basic fetch with identity memory.
      pulse_start(32'h100, 32'h40);
      check("basic_first_addr", mem_addr, 32'h100);
      wait_valid(40);
      check("basic_slot0", win_data[0*32 +: 32], 32'h100);
      check("basic_slot5", win_data[5*32 +: 32], 32'h144);
      check("basic_slot15", win_data[15*32 +: 32], 32'h1CC);

      // Backpressure with ignored start pulses.
      for (int i = 0; i < 10; i++) begin
         start     = (i % 3 == 0);
         base_addr = 32'h777;
         tick();
      end
      start = 1'b0;
      check("stall_valid", win_valid, 1'b1);
      check("stall_slot15", win_data[15*32 +: 32], 32'h1CC);

      // Back-to-back: accept and restart in the same DONE cycle.
      win_ready  = 1'b1;
      start      = 1'b1;
      base_addr  = 32'h200;
      row_stride = 32'h40;
      tick();
      win_ready = 1'b0;
      start     = 1'b0;
      check("b2b_rd_en", mem_rd_en, 1'b1);
      check("b2b_first_addr", mem_addr, 32'h200);
      wait_valid(40);
      handshake();

      // Address wrap-around.
      pulse_start(32'hFFFF_FFF8, 32'h10);
      check("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
      tick();
      check("wrap_addr1", mem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr2", mem_addr, 32'h0);
      tick();
      check("wrap_addr3", mem_addr, 32'h4);
      tick();
      check("wrap_addr4", mem_addr, 32'h8);
      wait_valid(40);
      handshake();

      // Reset in the middle of a fetch, at read index 7.
      pulse_start(32'h300, 32'h20);
      repeat (7) tick();
      Rst = 1'b0;
      tick();
      Rst = 1'b1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_rd_en", mem_rd_en, 1'b0);
      check("midrst_addr", mem_addr, 32'h0);
      check("midrst_valid", win_valid, 1'b0);
      check("midrst_data", win_data, '0);
      tick();
      check("midrst_no_capture", win_data, '0);
      pulse_start(32'h400, 32'h8);
      wait_valid(40);
      handshake();

      // Start while busy is ignored.
      pulse_start(32'h500, 32'h40);
      repeat (5) tick();
      start      = 1'b1;
      base_addr  = 32'h999;
      row_stride = 32'h4;
      tick();
      start = 1'b0;
      wait_valid(40);
      handshake();
      repeat (30) tick();
      check("no_second_window", win_valid, 1'b0);

      // Zero stride: every row repeats the same addresses.
      pulse_start(32'h600, 32'h0);
      wait_valid(40);
      check("zero_stride_slot12", win_data[12*32 +: 32], 32'h600);
      handshake();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         start      = ($urandom_range(0, 3) == 0);
         base_addr  = $urandom;
         row_stride = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         win_ready  = $urandom_range(0, 1);
         tick();
      end
      start     = 1'b0;
      win_ready = 1'b1;
      repeat (40) tick();
      win_ready = 1'b0;
      check("drain_addr_q", addr_q.size(), 0);
      check("drain_win_q", win_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
